clock_step_controller: RTL and testbench

CLOCK_STEP_CONTROLLER -- requirements
Module: clock_step_controller

---
 rtl/clock_step_controller.sv | 125 ++++++++++++
 tb/tb_clock_step_controller.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clock_step_controller.sv
// CPU step/run clock-enable generator: divides clk_100MHz by a loadable period and
// issues single-cycle cpu_ce pulses while running or for one single step.
module clock_step_controller #(
    parameter int unsigned DIV_W       = 26,
    parameter int unsigned DEFAULT_DIV = 50_000_000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    output logic             cpu_ce,
    output logic             clk_slow,
    output logic             step_done,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] tick_count
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    // A zero period would never reach terminal count, so it is clamped to 1.
    localparam logic [DIV_W-1:0] RESET_DIV =
        (DEFAULT_DIV == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic               cpu_ce_q, cpu_ce_d;
    logic               clk_slow_q, clk_slow_d;
    logic               step_done_q, step_done_d;
    logic [CNT_W-1:0]   tick_q, tick_d;
    logic               terminal_c;
    logic               counting_c;

    assign terminal_c = (cnt_q == (div_q - DIV_W'(1)));

    // Counting edges: the FSM stays in RUN/STEP and no load restarts the period.
    assign counting_c = !halt_req && !div_load &&
                        ((state_q == ST_RUN && run_req) || (state_q == ST_STEP));

    // State register and all registered outputs.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q     <= ST_HALT;
            div_q       <= RESET_DIV;
            cnt_q       <= '0;
            cpu_ce_q    <= 1'b0;
            clk_slow_q  <= 1'b0;
            step_done_q <= 1'b0;
            tick_q      <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            cpu_ce_q    <= cpu_ce_d;
            clk_slow_q  <= clk_slow_d;
            step_done_q <= step_done_d;
            tick_q      <= tick_d;
        end
    end

    // Next-state logic; halt_req dominates run_req, which dominates step_req.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (!halt_req) begin
                    if (run_req) begin
                        state_d = ST_RUN;
                    end else if (step_req) begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_RUN: begin
                if (halt_req || !run_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                if (halt_req || (!div_load && terminal_c)) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Period counter, divisor and pulse outputs; cnt returns to 0 on every non-counting edge.
    always_comb begin
        div_d       = div_q;
        cnt_d       = '0;
        cpu_ce_d    = 1'b0;
        step_done_d = 1'b0;
        clk_slow_d  = clk_slow_q;
        tick_d      = tick_q;
        if (div_load) begin
            div_d = (div_value == '0) ? DIV_W'(1) : div_value;
        end
        if (counting_c) begin
            if (terminal_c) begin
                cpu_ce_d    = 1'b1;
                clk_slow_d  = ~clk_slow_q;
                tick_d      = tick_q + CNT_W'(1);
                step_done_d = (state_q == ST_STEP);
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    assign cpu_ce     = cpu_ce_q;
    assign clk_slow   = clk_slow_q;
    assign step_done  = step_done_q;
    assign state      = state_q;
    assign tick_count = tick_q;

endmodule

// File: tb/tb_clock_step_controller.sv
// Self-checking bench for clock_step_controller: directed scenarios plus random
// stimulus, compared every cycle against a countdown-based behavioural model.
module tb_clock_step_controller;

    localparam int unsigned DIV_W   = 8;
    localparam int unsigned DEF_DIV = 6;
    localparam int unsigned CNT_W   = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             div_load = 1'b0;
    logic [DIV_W-1:0] div_value = '0;
    logic             run_req = 1'b0;
    logic             step_req = 1'b0;
    logic             halt_req = 1'b0;
    logic             cpu_ce;
    logic             clk_slow;
    logic             step_done;
    logic [1:0]       state;
    logic [CNT_W-1:0] tick_count;

    int n_checks = 0;
    int n_errors = 0;

    // Model: state, divisor, cycles left until the next pulse, and expected outputs.
    int m_state;
    int m_div;
    int m_left;
    int m_tick;
    bit m_ce;
    bit m_slow;
    bit m_done;

    clock_step_controller #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(DEF_DIV),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_100MHz(clk),
        .reset     (reset),
        .div_load  (div_load),
        .div_value (div_value),
        .run_req   (run_req),
        .step_req  (step_req),
        .halt_req  (halt_req),
        .cpu_ce    (cpu_ce),
        .clk_slow  (clk_slow),
        .step_done (step_done),
        .state     (state),
        .tick_count(tick_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // One clock edge of the behavioural model: entering RUN/STEP or loading the divisor
    // arms a countdown of m_div edges; a pulse fires when the countdown expires.
    task automatic model_edge(input bit rst, input bit ld, input int dv,
                              input bit run, input bit step, input bit halt);
        m_ce   = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_state = 0;
            m_div   = DEF_DIV;
            m_left  = 0;
            m_tick  = 0;
            m_slow  = 1'b0;
            return;
        end
        if (ld) m_div = (dv == 0) ? 1 : dv;
        if (m_state == 0) begin
            if (!halt && run) begin
                m_state = 1;
                m_left  = m_div;
            end else if (!halt && step) begin
                m_state = 2;
                m_left  = m_div;
            end
        end else if (halt || (m_state == 1 && !run)) begin
            m_state = 0;
        end else if (ld) begin
            m_left = m_div;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_ce   = 1'b1;
                m_slow = !m_slow;
                m_tick = (m_tick + 1) % (1 << CNT_W);
                m_left = m_div;
                if (m_state == 2) begin
                    m_done  = 1'b1;
                    m_state = 0;
                end
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit ld, input int dv,
                         input bit run, input bit step, input bit halt);
        reset     = rst;
        div_load  = ld;
        div_value = DIV_W'(dv);
        run_req   = run;
        step_req  = step;
        halt_req  = halt;
        @(posedge clk);
        model_edge(rst, ld, dv, run, step, halt);
        #1;
        chk("cpu_ce", int'(cpu_ce), int'(m_ce));
        chk("clk_slow", int'(clk_slow), int'(m_slow));
        chk("step_done", int'(step_done), int'(m_done));
        chk("state", int'(state), m_state);
        chk("tick_count", int'(tick_count), m_tick);
    endtask

    initial begin
        bit run_lvl;
        run_lvl = 1'b0;

        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("reset_state", int'(state), 0);
        chk("reset_tick", int'(tick_count), 0);

        // Divisor 4 run: pulses 4, 8, 12 cycles after the RUN edge.
        cycle(0, 1, 4, 0, 0, 0);
        for (int i = 0; i < 13; i++) cycle(0, 0, 0, 1, 0, 0);
        chk("run4_tick", int'(tick_count), 3);
        chk("run4_slow", int'(clk_slow), 1);
        cycle(0, 0, 0, 0, 0, 0);

        // Single step with divisor 3; a repeated step_req during STEP is ignored.
        cycle(0, 1, 3, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0);
        chk("step_tick", int'(tick_count), 4);
        chk("step_state", int'(state), 0);

        // Divisor 5 run, halt_req lands on the terminal-count edge.
        cycle(0, 1, 5, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 1);
        chk("halt_term_ce", int'(cpu_ce), 0);
        chk("halt_term_tick", int'(tick_count), 4);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);

        // Divisor 0 clamps to 1; also drives tick_count through its wrap.
        cycle(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Explicit divisor 1 run for 17 pulses from a cleared counter.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 1, 0, 0);
        chk("wrap_15", int'(tick_count), 15);
        cycle(0, 0, 0, 1, 0, 0);
        chk("wrap_0", int'(tick_count), 0);
        cycle(0, 0, 0, 1, 0, 0);
        chk("wrap_1", int'(tick_count), 1);
        cycle(0, 0, 0, 0, 0, 0);

        // Reset mid-RUN at cnt=2, run_req held: re-enter RUN with the reset divisor.
        cycle(0, 1, 5, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        chk("midrun_rst_state", int'(state), 0);
        chk("midrun_rst_ce", int'(cpu_ce), 0);
        for (int i = 0; i < 14; i++) cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Random mix of all requests.
        for (int i = 0; i < 3000; i++) begin
            bit r_rst, r_ld, r_step, r_halt;
            int r_dv;
            if ($urandom_range(0, 19) == 0) run_lvl = !run_lvl;
            r_rst  = ($urandom_range(0, 299) == 0);
            r_ld   = ($urandom_range(0, 29) == 0);
            r_step = ($urandom_range(0, 9) == 0);
            r_halt = ($urandom_range(0, 39) == 0);
            r_dv   = int'($urandom_range(0, 7));
            cycle(r_rst, r_ld, r_dv, run_lvl, r_step, r_halt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
